// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, builds ALUCtrl,
// forwards from EX/MEM and MEM/WB, and flags load-use hazards to decode.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IdValid,
  input  logic [WIDTH-1:0]   IdRsData,
  input  logic [WIDTH-1:0]   IdRtData,
  input  logic [WIDTH-1:0]   IdImm,
  input  logic [REGBITS-1:0] IdRs,
  input  logic [REGBITS-1:0] IdRt,
  input  logic [REGBITS-1:0] IdRd,
  input  logic [1:0]         IdALUOp,
  input  logic [5:0]         IdFunct,
  input  logic               IdALUSrc,
  input  logic               IdRegDst,
  input  logic               IdRegWrite,
  input  logic               IdMemRead,
  input  logic               IdMemWrite,
  input  logic               IdMemToReg,
  input  logic               IdUsesRt,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ExMemRegWrite,
  input  logic [REGBITS-1:0] ExMemRd,
  input  logic [WIDTH-1:0]   ExMemResult,
  input  logic               MemWbRegWrite,
  input  logic [REGBITS-1:0] MemWbRd,
  input  logic [WIDTH-1:0]   MemWbResult,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2:0]         ALUCtrl,
  output logic [WIDTH-1:0]   StoreData,
  output logic               ExValid,
  output logic [REGBITS-1:0] ExDest,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExMemToReg,
  output logic               IllegalOp,
  output logic               LoadUse
);

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] dest;
    logic               alu_src;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               illegal;
    logic [2:0]         alu_ctrl;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  logic [2:0] dec_ctrl;
  logic       dec_ill;

  always_comb begin
    dec_ctrl = 3'b100;
    dec_ill  = 1'b0;
    unique case (IdALUOp)
      2'b00: dec_ctrl = 3'b100;
      2'b01: dec_ctrl = 3'b110;
      2'b11: dec_ctrl = 3'b001;
      2'b10: begin
        unique case (IdFunct)
          6'b100000: dec_ctrl = 3'b100;
          6'b100001: dec_ctrl = 3'b101;
          6'b100010: dec_ctrl = 3'b110;
          6'b100100: dec_ctrl = 3'b000;
          6'b100101: dec_ctrl = 3'b001;
          6'b101010: dec_ctrl = 3'b011;
          default:   dec_ill  = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    d            = '0;
    d.valid      = IdValid;
    d.rs_data    = IdRsData;
    d.rt_data    = IdRtData;
    d.imm        = IdImm;
    d.rs         = IdRs;
    d.rt         = IdRt;
    d.dest       = IdRegDst ? IdRd : IdRt;
    d.alu_src    = IdALUSrc;
    d.reg_write  = IdRegWrite;
    d.mem_read   = IdMemRead;
    d.mem_write  = IdMemWrite;
    d.mem_to_reg = IdMemToReg;
    d.illegal    = dec_ill;
    d.alu_ctrl   = dec_ctrl;
  end

  // Reset and flush both leave an ADD-coded bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      q.alu_ctrl <= 3'b100;
    end else if (Flush) begin
      q          <= '0;
      q.alu_ctrl <= 3'b100;
    end else if (!Stall) begin
      q <= d;
    end
  end

  function automatic logic [WIDTH-1:0] fwd(
    input logic [REGBITS-1:0] r,
    input logic [WIDTH-1:0]   val,
    input logic               ex_we,
    input logic [REGBITS-1:0] ex_rd,
    input logic [WIDTH-1:0]   ex_res,
    input logic               wb_we,
    input logic [REGBITS-1:0] wb_rd,
    input logic [WIDTH-1:0]   wb_res
  );
    if (ex_we && ex_rd != '0 && ex_rd == r)
      return ex_res;
    else if (wb_we && wb_rd != '0 && wb_rd == r)
      return wb_res;
    else
      return val;
  endfunction

  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  assign fwd_rs = fwd(q.rs, q.rs_data,
                      ExMemRegWrite, ExMemRd, ExMemResult,
                      MemWbRegWrite, MemWbRd, MemWbResult);
  assign fwd_rt = fwd(q.rt, q.rt_data,
                      ExMemRegWrite, ExMemRd, ExMemResult,
                      MemWbRegWrite, MemWbRd, MemWbResult);

  assign A         = fwd_rs;
  assign StoreData = fwd_rt;
  assign B         = q.alu_src ? q.imm : fwd_rt;

  assign ALUCtrl    = q.alu_ctrl;
  assign ExValid    = q.valid;
  assign ExDest     = q.dest;
  assign IllegalOp  = q.valid & q.illegal;
  assign ExRegWrite = q.valid & q.reg_write & ~q.illegal;
  assign ExMemRead  = q.valid & q.mem_read;
  assign ExMemWrite = q.valid & q.mem_write;
  assign ExMemToReg = q.valid & q.mem_to_reg;

  assign LoadUse = ExMemRead & (q.dest != '0) &
                   ((q.dest == IdRs) | (IdUsesRt & (q.dest == IdRt)));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases followed by randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IdValid;
  logic [31:0] IdRsData, IdRtData, IdImm;
  logic [4:0]  IdRs, IdRt, IdRd;
  logic [1:0]  IdALUOp;
  logic [5:0]  IdFunct;
  logic        IdALUSrc, IdRegDst, IdRegWrite, IdMemRead;
  logic        IdMemWrite, IdMemToReg, IdUsesRt;
  logic        Stall, Flush;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [31:0] ExMemResult, MemWbResult;
  logic [31:0] A, B, StoreData;
  logic [2:0]  ALUCtrl;
  logic        ExValid;
  logic [4:0]  ExDest;
  logic        ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;
  logic        IllegalOp, LoadUse;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .IdValid(IdValid),
    .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
    .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
    .IdALUOp(IdALUOp), .IdFunct(IdFunct),
    .IdALUSrc(IdALUSrc), .IdRegDst(IdRegDst),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg),
    .IdUsesRt(IdUsesRt), .Stall(Stall), .Flush(Flush),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd),
    .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd),
    .MemWbResult(MemWbResult),
    .A(A), .B(B), .ALUCtrl(ALUCtrl), .StoreData(StoreData),
    .ExValid(ExValid), .ExDest(ExDest),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .IllegalOp(IllegalOp), .LoadUse(LoadUse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        regdst, alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        rw, mr, mw, m2r;
  } ins_t;

  ins_t m;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction-level meaning of ALUOp/Funct: {illegal, ctrl}.
  function automatic logic [3:0] op_meaning(input logic [1:0] op,
                                            input logic [5:0] fn);
    if (op == 2'b00) return {1'b0, 3'd4};
    if (op == 2'b01) return {1'b0, 3'd6};
    if (op == 2'b11) return {1'b0, 3'd1};
    case (fn)
      6'd32:   return {1'b0, 3'd4};
      6'd33:   return {1'b0, 3'd5};
      6'd34:   return {1'b0, 3'd6};
      6'd36:   return {1'b0, 3'd0};
      6'd37:   return {1'b0, 3'd1};
      6'd42:   return {1'b0, 3'd3};
      default: return {1'b1, 3'd4};
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r,
                                          input logic [31:0] v);
    if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == r) return ExMemResult;
    if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == r) return MemWbResult;
    return v;
  endfunction

  function automatic ins_t cur_ins();
    ins_t t;
    t = '{IdValid, IdRsData, IdRtData, IdImm, IdRs, IdRt, IdRd,
          IdRegDst, IdALUSrc, IdALUOp, IdFunct,
          IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg};
    return t;
  endfunction

  task automatic check_all(input string tag);
    logic [3:0]  om;
    logic [4:0]  dst;
    logic [31:0] sd;
    logic        lu;
    om  = op_meaning(m.aluop, m.funct);
    dst = m.regdst ? m.rd : m.rt;
    sd  = ref_fwd(m.rt, m.rtd);
    lu  = m.valid && m.mr && dst != 0 &&
          (dst == IdRs || (IdUsesRt && dst == IdRt));
    check({tag, ".valid"}, 32'(ExValid), 32'(m.valid));
    check({tag, ".dest"}, 32'(ExDest), 32'(dst));
    check({tag, ".ctrl"}, 32'(ALUCtrl), 32'(om[2:0]));
    check({tag, ".ill"}, 32'(IllegalOp), 32'(m.valid & om[3]));
    check({tag, ".rw"}, 32'(ExRegWrite), 32'(m.valid & m.rw & ~om[3]));
    check({tag, ".mr"}, 32'(ExMemRead), 32'(m.valid & m.mr));
    check({tag, ".mw"}, 32'(ExMemWrite), 32'(m.valid & m.mw));
    check({tag, ".m2r"}, 32'(ExMemToReg), 32'(m.valid & m.m2r));
    check({tag, ".A"}, A, ref_fwd(m.rs, m.rsd));
    check({tag, ".B"}, B, m.alusrc ? m.imm : sd);
    check({tag, ".sd"}, StoreData, sd);
    check({tag, ".lu"}, 32'(LoadUse), 32'(lu));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (Flush) m = '0;
    else if (!Stall) m = cur_ins();
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    {IdValid, IdRegDst, IdALUSrc, IdRegWrite, IdMemRead} = '0;
    {IdMemWrite, IdMemToReg, IdUsesRt, Stall, Flush} = '0;
    {IdRsData, IdRtData, IdImm} = '0;
    {IdRs, IdRt, IdRd, IdALUOp, IdFunct} = '0;
    {ExMemRegWrite, MemWbRegWrite, ExMemRd, MemWbRd} = '0;
    {ExMemResult, MemWbResult} = '0;
  endtask

  logic [5:0] legal_fn [6] = '{6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd42};

  initial begin
    idle();
    rst = 1'b1;
    m = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.ctrl100", 32'(ALUCtrl), 32'd4);
    rst = 1'b0;

    // valid store-like add, then asynchronous reset mid-cycle
    IdValid = 1; IdALUOp = 2'b00; IdRegWrite = 1; IdMemWrite = 1;
    IdRs = 1; IdRt = 2; IdRsData = 7; IdRtData = 8;
    step("add");
    check("add.valid", 32'(ExValid), 32'd1);
    #2 rst = 1'b1;
    m = '0;
    #1;
    check("arst.valid", 32'(ExValid), 32'd0);
    check("arst.rw", 32'(ExRegWrite), 32'd0);
    check("arst.mw", 32'(ExMemWrite), 32'd0);
    check("arst.ctrl", 32'(ALUCtrl), 32'd4);
    @(negedge clk);
    rst = 1'b0;

    // slt, then an unsupported funct
    idle();
    IdValid = 1; IdALUOp = 2'b10; IdFunct = 6'b101010; IdRegWrite = 1;
    IdRs = 1; IdRt = 2; IdRd = 3; IdRegDst = 1;
    IdRsData = 5; IdRtData = 9;
    step("slt");
    check("slt.ctrl", 32'(ALUCtrl), 32'd3);
    check("slt.A", A, 32'd5);
    check("slt.B", B, 32'd9);
    IdFunct = 6'b000111;
    step("bad_fn");
    check("bad_fn.ill", 32'(IllegalOp), 32'd1);
    check("bad_fn.rw", 32'(ExRegWrite), 32'd0);

    // EX/MEM priority, then r0 suppression while stalled
    IdALUOp = 2'b00; IdRs = 3; IdRsData = 32'hAA;
    ExMemRegWrite = 1; ExMemRd = 3; ExMemResult = 32'h11;
    MemWbRegWrite = 1; MemWbRd = 3; MemWbResult = 32'h22;
    step("fwd_ex");
    check("fwd_ex.A", A, 32'h11);
    Stall = 1; ExMemRd = 0; MemWbRd = 0;
    #1 check_all("fwd_r0");
    check("fwd_r0.A", A, 32'hAA);
    Stall = 0;

    // immediate B with forwarded store data
    idle();
    IdValid = 1; IdALUSrc = 1; IdImm = 32'hFFFF_FFFC; IdRt = 4;
    IdMemWrite = 1;
    MemWbRegWrite = 1; MemWbRd = 4; MemWbResult = 32'h40;
    step("imm");
    check("imm.B", B, 32'hFFFF_FFFC);
    check("imm.sd", StoreData, 32'h40);
    check("imm.ctrl", 32'(ALUCtrl), 32'd4);

    // load-use detection and the responding bubble
    idle();
    IdValid = 1; IdMemRead = 1; IdMemToReg = 1; IdRegWrite = 1;
    IdRt = 8; IdRs = 1;
    step("lw");
    IdRs = 8; IdMemRead = 0; IdMemToReg = 0;
    #1 check("lu.set", 32'(LoadUse), 32'd1);
    Flush = 1;
    step("lu_flush");
    check("lu.valid", 32'(ExValid), 32'd0);
    check("lu.clr", 32'(LoadUse), 32'd0);
    Flush = 0;

    // stall hold, then stall+flush
    IdValid = 1; IdRegWrite = 1; IdRs = 5; IdRsData = 32'h55;
    step("pre_stall");
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      IdRs = 5'(i + 9); IdRsData = $urandom; IdValid = 1'(i);
      step("stall");
      check("stall.A", A, 32'h55);
    end
    Flush = 1;
    step("stall_flush");
    check("stall_flush.valid", 32'(ExValid), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      IdValid = 1'($urandom_range(0, 3) != 0);
      IdRsData = $urandom; IdRtData = $urandom; IdImm = $urandom;
      IdRs = 5'($urandom_range(0, 7));
      IdRt = 5'($urandom_range(0, 7));
      IdRd = 5'($urandom_range(0, 7));
      IdALUOp = 2'($urandom);
      IdFunct = ($urandom_range(0, 3) != 0) ?
                legal_fn[$urandom_range(0, 5)] : 6'($urandom);
      {IdALUSrc, IdRegDst, IdRegWrite, IdMemRead} = 4'($urandom);
      {IdMemWrite, IdMemToReg, IdUsesRt} = 3'($urandom);
      Stall = 1'($urandom_range(0, 3) == 0);
      Flush = 1'($urandom_range(0, 7) == 0);
      ExMemRegWrite = 1'($urandom); MemWbRegWrite = 1'($urandom);
      ExMemRd = 5'($urandom_range(0, 7));
      MemWbRd = 5'($urandom_range(0, 7));
      ExMemResult = $urandom; MemWbResult = $urandom;
      #1 check_all("rnd_comb");
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded operands and control from the decode stage, and generates the 3-bit ALUCtrl from ALUOp/Funct.
- Applies EX/MEM and MEM/WB forwarding to produce the ALU A/B operands.
- Flags load-use hazards back to the decode stage and the PC logic.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REGBITS, 5, register index width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- IdValid  input  1  decode stage presents a valid instruction.
- IdRsData / IdRtData  input  WIDTH  register-file read data.
- IdImm  input  WIDTH  extended immediate.
- IdRs / IdRt / IdRd  input  REGBITS  register indices.
- IdALUOp  input  2  00 add, 01 sub, 10 R-type (use Funct), 11 or.
- IdFunct  input  6  R-type function field.
- IdALUSrc  input  1  1 selects immediate for B.
- IdRegDst  input  1  1 selects Rd as destination, 0 selects Rt.
- IdRegWrite / IdMemRead / IdMemWrite / IdMemToReg  input  1  control bits.
- IdUsesRt  input  1  decode-stage instruction reads Rt.
- Stall  input  1  hold the register contents.
- Flush  input  1  insert a bubble.
- ExMemRegWrite  input  1  EX/MEM stage writes a register.
- ExMemRd  input  REGBITS  EX/MEM destination index.
- ExMemResult  input  WIDTH  EX/MEM result.
- MemWbRegWrite  input  1  MEM/WB stage writes a register.
- MemWbRd  input  REGBITS  MEM/WB destination index.
- MemWbResult  input  WIDTH  MEM/WB result.
- A / B  output  WIDTH  ALU operands.
- ALUCtrl  output  3  ALU operation select.
- StoreData  output  WIDTH  forwarded Rt value for stores.
- ExValid  output  1  registered valid bit.
- ExDest  output  REGBITS  selected destination index.
- ExRegWrite / ExMemRead / ExMemWrite / ExMemToReg  output  1  registered control bits, gated by valid.
- IllegalOp  output  1  R-type Funct not supported.
- LoadUse  output  1  load-use hazard request to decode and PC logic.

Behaviour:
- Reset (asynchronous, active-high):
  - All registered fields clear to 0: ExValid=0, all control bits 0, ExDest=0, ALUCtrl=3'b100.
  - LoadUse=0 and IllegalOp=0.
  - Reset mid-operation discards the held instruction immediately, with no clock edge required.
- Register update priority per rising edge: Flush > Stall > load.
  - Flush: bubble. ExValid=0, all control 0, data fields 0.
  - Stall (without Flush): every field holds.
  - Otherwise: capture all Id* inputs; ExValid=IdValid.
- A captured instruction with IdValid=0 behaves as a bubble: control outputs are forced to 0.
- ALUCtrl decode, registered at capture:
  - ALUOp 00 -> 100 (ADD).
  - ALUOp 01 -> 110 (SUB).
  - ALUOp 11 -> 001 (OR).
  - ALUOp 10, by Funct:
    - 100000 -> 100.
    - 100001 -> 101.
    - 100010 -> 110.
    - 100100 -> 000.
    - 100101 -> 001.
    - 101010 -> 011.
    - Any other Funct: ALUCtrl=100, IllegalOp=1, ExRegWrite forced 0.
  - ALUCtrl never takes 010 or 111.
- ExDest = IdRegDst ? IdRd : IdRt, registered at capture.
- Forwarding is combinational, from registered Rs/Rt against the current forwarding inputs, evaluated per operand.
  - EX/MEM has priority: ExMemRegWrite && ExMemRd!=0 && ExMemRd==reg selects ExMemResult.
  - Else MEM/WB: MemWbRegWrite && MemWbRd!=0 && MemWbRd==reg selects MemWbResult.
  - Else the registered data is used.
  - Register 0 is never forwarded.
- Operand selection:
  - A = forwarded Rs.
  - StoreData = forwarded Rt.
  - B = ALUSrc ? registered Imm : forwarded Rt.
- LoadUse (combinational) = ExValid & ExMemRead & ExDest!=0 & (ExDest==IdRs | (IdUsesRt & ExDest==IdRt)).
  - The block does not act on its own LoadUse.
  - The hazard controller drives Flush=1 for one cycle in response; decode holds.
- Simultaneous Stall and Flush: Flush wins.
- Stall does not freeze forwarding: A/B track the forwarding inputs every cycle.
- Latency: one cycle from Id* inputs to registered outputs; A/B/StoreData settle combinationally after that edge.

Test Plan:
- Reset asserted mid-cycle with ExValid=1 -> ExValid, ExRegWrite, ExMemWrite drop to 0 before the next edge; ALUCtrl=100.
- IdALUOp=10, IdFunct=101010, IdRsData=5, IdRtData=9, no forwarding -> next cycle ALUCtrl=011, A=5, B=9; IdFunct=000111 -> IllegalOp=1, ExRegWrite=0.
- Registered Rs=3, ExMemRegWrite=1, ExMemRd=3, ExMemResult=0x11; MemWbRegWrite=1, MemWbRd=3, MemWbResult=0x22 -> A=0x11. Repeat with ExMemRd=0 and MemWbRd=0 -> A = registered RsData.
- IdALUSrc=1, IdImm=0xFFFFFFFC, Rt forwarded 0x40 -> B=0xFFFFFFFC, StoreData=0x40, ALUCtrl=100.
- Registered lw with ExDest=8, ExMemRead=1; IdRs=8 -> LoadUse=1. Then Flush=1 for one cycle -> ExValid=0, LoadUse=0.
- Stall=1 for 3 cycles while Id* inputs change -> all registered outputs hold. Stall=1 and Flush=1 together -> bubble.
